// File: rtl/mul_pkg.sv
// Shared types for the sequential shift-add multiplier: FSM state encoding
// and the iteration counter width helper.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // The counter must hold the value WIDTH itself, hence WIDTH+1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/twos_abs.sv
// Combinational conditional two's-complement negate: o_y = i_en ? -i_x : i_x.
module twos_abs #(
    parameter int W = 32
) (
    input  logic         i_en,
    input  logic [W-1:0] i_x,
    output logic [W-1:0] o_y
);

    assign o_y = i_en ? ({W{1'b0}} - i_x) : i_x;

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier with signed/unsigned mode, start/busy/done
// handshake and optional early exit once the remaining multiplier bits are zero.
module seq_multiplier
    import mul_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_op,
    input  logic [WIDTH-1:0]     dataA,
    input  logic [WIDTH-1:0]     dataB,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   dataOut
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t               r_state;
    state_t               w_next;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_prod;
    logic [2*WIDTH-1:0]   r_data_out;
    logic                 r_neg;
    logic [CNT_W-1:0]     r_count;

    logic                 w_neg_a;
    logic                 w_neg_b;
    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    logic [2*WIDTH-1:0]   w_fix;
    logic [WIDTH-1:0]     w_mplier_next;
    logic                 w_last;

    assign w_neg_a       = signed_op & dataA[WIDTH-1];
    assign w_neg_b       = signed_op & dataB[WIDTH-1];
    assign w_mplier_next = r_mplier >> 1;

    // -2^(WIDTH-1) negates to itself, which is still the right unsigned magnitude.
    twos_abs #(.W(WIDTH)) u_abs_a (
        .i_en (w_neg_a),
        .i_x  (dataA),
        .o_y  (w_abs_a)
    );

    twos_abs #(.W(WIDTH)) u_abs_b (
        .i_en (w_neg_b),
        .i_x  (dataB),
        .o_y  (w_abs_b)
    );

    twos_abs #(.W(2 * WIDTH)) u_fix (
        .i_en (r_neg),
        .i_x  (r_prod),
        .o_y  (w_fix)
    );

    // Last RUN step: all WIDTH bits consumed, or nothing left to add.
    assign w_last = (r_count == CNT_W'(WIDTH - 1)) ||
                    (EARLY_EXIT && (w_mplier_next == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = RUN;
            RUN:     if (w_last) w_next = FIX;
            FIX:     w_next = DONE;
            DONE:    w_next = start ? RUN : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == RUN) || (r_state == FIX);
        done = (r_state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_prod     <= '0;
            r_data_out <= '0;
            r_neg      <= 1'b0;
            r_count    <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_mcand  <= {{WIDTH{1'b0}}, w_abs_a};
                        r_mplier <= w_abs_b;
                        r_neg    <= signed_op & (dataA[WIDTH-1] ^ dataB[WIDTH-1]);
                        r_prod   <= '0;
                        r_count  <= '0;
                    end
                end
                RUN: begin
                    if (r_mplier[0]) begin
                        r_prod <= r_prod + r_mcand;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= w_mplier_next;
                    r_count  <= r_count + CNT_W'(1);
                end
                FIX: begin
                    r_data_out <= w_fix;
                end
                default: begin
                end
            endcase
        end
    end

    assign dataOut = r_data_out;

endmodule
